uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART transmitter (19200 baud, CLKS_PER_BIT=521 at the system clock) between NUM_REQ byte requesters.
- Accepts one byte at a time from the granted requester over a valid/ready handshake.
- Issues a one-cycle start pulse to the transmitter and waits for its done pulse.
- Holds the grant across packets (req_last), up to a burst cap.
- Enforces an inter-frame gap and a watchdog on the transmitter.

---
 rtl/uart_tx_arbiter_if.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the signals between the byte requesters, the arbiter and the UART
// transmitter.
//   slave  : the arbiter side (takes requests and tx_done, drives grants/tx)
//   master : the requester/transmitter side
// Signals:
//   req_valid[N], req_data[8N], req_last[N] : per-requester byte offer
//   req_ready[N]                            : one-hot accept from the arbiter
//   tx_dv, tx_byte                          : start pulse and byte to the UART
//   tx_done                                 : end-of-frame pulse from the UART
//   grant_id, busy, timeout_err             : status
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 tx_done;
    logic [IDW-1:0]       grant_id;
    logic                 busy;
    logic                 timeout_err;

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_dv, tx_byte, grant_id, busy, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_dv, tx_byte, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// requesters. The owner keeps the grant across a packet (until req_last) up to
// MAX_BURST bytes, an optional idle gap follows every frame, and a watchdog
// aborts a frame whose tx_done never arrives.
// Ports:
//   tx_clk   : system clock, rising edge
//   tx_rst_n : asynchronous active-low reset
//   bus      : uart_tx_arbiter_if.slave (requests, tx handshake, status)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no owner; pick the next valid requester from rr_ptr upward
// ISSUE     | offer req_ready to the owner; accept a byte or give up
// WAIT_DONE | tx_dv issued, waiting for tx_done with the watchdog running
// GAP       | inter-frame idle time after tx_done
// NEXT      | decide whether the owner keeps the grant for another byte
// RELEASE   | advance rr_ptr past the owner and return to IDLE
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 521,
    parameter int MAX_BURST    = 16,
    parameter int GAP_CLKS     = 0,
    parameter int TIMEOUT_CLKS = CLKS_PER_BIT * 12
) (
    input  logic             tx_clk,
    input  logic             tx_rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDW  = $clog2(NUM_REQ);
    localparam int TMAX = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [7:0]     MAX_B    = 8'(MAX_BURST);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);
    localparam logic [TW-1:0]  TMO_LOAD = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0]  GAP_LOAD = (GAP_CLKS > 0) ? TW'(GAP_CLKS - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_GAP,
        S_NEXT,
        S_RELEASE
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_grant_id;
    logic [IDW-1:0]     r_rr_ptr;
    logic [7:0]         r_burst_cnt;
    logic [7:0]         r_tx_byte;
    logic               r_tx_dv;
    logic               r_timeout_err;
    logic               r_last_q;
    logic [TW-1:0]      r_timer;

    logic [IDW-1:0]     w_win_hi;
    logic [IDW-1:0]     w_win_lo;
    logic               w_found_hi;
    logic [IDW-1:0]     w_winner;
    logic [7:0]         w_sel_data;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [NUM_REQ-1:0] w_ready;

    // Rotating priority: the lowest valid index at or above rr_ptr wins; if
    // there is none, wrap around to the lowest valid index overall.
    always_comb begin
        w_win_hi   = '0;
        w_win_lo   = '0;
        w_found_hi = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[k]) begin
                w_win_lo = IDW'(k);
                if (IDW'(k) >= r_rr_ptr) begin
                    w_win_hi   = IDW'(k);
                    w_found_hi = 1'b1;
                end
            end
        end
    end

    assign w_winner = w_found_hi ? w_win_hi : w_win_lo;

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (IDW'(k) == r_grant_id) begin
                w_sel_data = bus.req_data[8*k +: 8];
            end
        end
    end

    assign w_sel_valid = bus.req_valid[r_grant_id];
    assign w_sel_last  = bus.req_last[r_grant_id];

    always_comb begin
        w_ready = '0;
        if (r_state == S_ISSUE) begin
            w_ready[r_grant_id] = w_sel_valid;
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.tx_dv       = r_tx_dv;
    assign bus.tx_byte     = r_tx_byte;
    assign bus.grant_id    = r_grant_id;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.timeout_err = r_timeout_err;

    // r_timer is shared: watchdog in WAIT_DONE, gap length in GAP. Both count
    // down to a terminal zero.
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            r_state       <= S_IDLE;
            r_grant_id    <= '0;
            r_rr_ptr      <= '0;
            r_burst_cnt   <= '0;
            r_tx_byte     <= '0;
            r_tx_dv       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_last_q      <= 1'b0;
            r_timer       <= '0;
        end else begin
            r_tx_dv       <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|bus.req_valid) begin
                        r_grant_id  <= w_winner;
                        r_burst_cnt <= '0;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_sel_valid) begin
                        r_tx_byte <= w_sel_data;
                        r_last_q  <= w_sel_last;
                        if (r_burst_cnt != MAX_B) begin
                            r_burst_cnt <= r_burst_cnt + 8'd1;
                        end
                        r_tx_dv   <= 1'b1;
                        r_timer   <= TMO_LOAD;
                        r_state   <= S_WAIT_DONE;
                    end else begin
                        r_state <= S_RELEASE;
                    end
                end
                S_WAIT_DONE: begin
                    // A done that lands on the expiry cycle wins over the abort.
                    if (bus.tx_done) begin
                        if (GAP_CLKS > 0) begin
                            r_timer <= GAP_LOAD;
                            r_state <= S_GAP;
                        end else begin
                            r_state <= S_NEXT;
                        end
                    end else if (r_timer == '0) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_RELEASE;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_timer == '0) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_NEXT: begin
                    if (!r_last_q && (r_burst_cnt < MAX_B)) begin
                        r_state <= S_ISSUE;
                    end else begin
                        r_state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    r_rr_ptr <= (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. dut_a uses the default parameters; dut_b uses
// MAX_BURST=2, GAP_CLKS=3 and a short watchdog (CLKS_PER_BIT=10 -> 120 clocks).
module tb_uart_tx_arbiter;
    localparam int NR = 4;

    logic tx_clk = 1'b0;
    logic tx_rst_n;

    always #5 tx_clk = ~tx_clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR)) if_a ();
    uart_tx_arbiter_if #(.NUM_REQ(NR)) if_b ();

    uart_tx_arbiter #(.NUM_REQ(NR)) dut_a (
        .tx_clk   (tx_clk),
        .tx_rst_n (tx_rst_n),
        .bus      (if_a)
    );

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .CLKS_PER_BIT (10),
        .MAX_BURST    (2),
        .GAP_CLKS     (3)
    ) dut_b (
        .tx_clk   (tx_clk),
        .tx_rst_n (tx_rst_n),
        .bus      (if_b)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          exp_gid;
        logic [7:0]  exp_byte;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        @(negedge tx_clk);
    endtask

    function automatic logic [31:0] get_dv(input bit b);
        return b ? 32'(if_b.tx_dv) : 32'(if_a.tx_dv);
    endfunction
    function automatic logic [31:0] get_busy(input bit b);
        return b ? 32'(if_b.busy) : 32'(if_a.busy);
    endfunction
    function automatic logic [31:0] get_gid(input bit b);
        return b ? 32'(if_b.grant_id) : 32'(if_a.grant_id);
    endfunction
    function automatic logic [31:0] get_byte(input bit b);
        return b ? 32'(if_b.tx_byte) : 32'(if_a.tx_byte);
    endfunction
    function automatic logic [31:0] get_ready(input bit b);
        return b ? 32'(if_b.req_ready) : 32'(if_a.req_ready);
    endfunction
    function automatic logic [31:0] get_terr(input bit b);
        return b ? 32'(if_b.timeout_err) : 32'(if_a.timeout_err);
    endfunction

    task automatic set_in(input bit b, input logic [3:0] v, input logic [31:0] d, input logic [3:0] l);
        if (b) begin
            if_b.req_valid = v;
            if_b.req_data  = d;
            if_b.req_last  = l;
        end else begin
            if_a.req_valid = v;
            if_a.req_data  = d;
            if_a.req_last  = l;
        end
    endtask

    task automatic set_done(input bit b, input logic d);
        if (b) if_b.tx_done = d;
        else   if_a.tx_done = d;
    endtask

    task automatic pulse_done(input bit b);
        set_done(b, 1'b1);
        tick();
        set_done(b, 1'b0);
    endtask

    // Ticks until tx_dv is seen (bounded), then checks owner and byte.
    task automatic wait_dv(input bit b, input string name, input int exp_gid,
                           input logic [7:0] exp_byte, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (get_dv(b) != 32'd1 && lat < 40);
        check({name, "_dv"}, get_dv(b), 32'd1);
        check({name, "_gid"}, get_gid(b), 32'(exp_gid));
        check({name, "_byte"}, get_byte(b), 32'(exp_byte));
    endtask

    task automatic wait_idle(input bit b, input string name);
        int n;
        n = 0;
        while (get_busy(b) != 32'd0 && n < 40) begin
            tick();
            n++;
        end
        check({name, "_idle"}, get_busy(b), 32'd0);
    endtask

    task automatic reset_dut();
        tx_rst_n = 1'b0;
        repeat (2) tick();
        tx_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t vecs[11];
        int   lat;
        int   n;
        logic seen;

        // Expected owners follow rr_ptr starting at 0 after reset and moving
        // to grant+1 after every release.
        vecs[0]  = '{4'b1111, 32'hD3C2B1A0, 0, 8'hA0};
        vecs[1]  = '{4'b1111, 32'h13121110, 1, 8'h11};
        vecs[2]  = '{4'b1111, 32'h27262524, 2, 8'h26};
        vecs[3]  = '{4'b1111, 32'h3B3A3938, 3, 8'h3B};
        vecs[4]  = '{4'b1111, 32'h4F4E4D4C, 0, 8'h4C};
        vecs[5]  = '{4'b1001, 32'hF0E1D2C3, 3, 8'hF0};
        vecs[6]  = '{4'b0110, 32'h8899AABB, 1, 8'hAA};
        vecs[7]  = '{4'b0001, 32'h01234567, 0, 8'h67};
        vecs[8]  = '{4'b1010, 32'h5A5B5C5D, 1, 8'h5C};
        vecs[9]  = '{4'b1010, 32'hE5E6E7E8, 3, 8'hE5};
        vecs[10] = '{4'b0001, 32'h9A9B9C9D, 0, 8'h9D};

        tx_rst_n = 1'b0;
        set_in(1'b0, 4'b0, 32'h0, 4'b0);
        set_in(1'b1, 4'b0, 32'h0, 4'b0);
        set_done(1'b0, 1'b0);
        set_done(1'b1, 1'b0);
        @(negedge tx_clk);
        reset_dut();

        check("rst_dv", get_dv(0), 32'd0);
        check("rst_busy", get_busy(0), 32'd0);
        check("rst_gid", get_gid(0), 32'd0);
        check("rst_ready", get_ready(0), 32'd0);
        check("rst_byte", get_byte(0), 32'd0);
        check("rst_terr", get_terr(0), 32'd0);
        check("rst_busy_b", get_busy(1), 32'd0);

        // Single request on port 2
        set_in(1'b0, 4'b0100, 32'h00E30000, 4'b1111);
        tick();
        check("s1_ready", get_ready(0), 32'h4);
        check("s1_dv_early", get_dv(0), 32'd0);
        tick();
        check("s1_dv", get_dv(0), 32'd1);
        check("s1_byte", get_byte(0), 32'hE3);
        check("s1_gid", get_gid(0), 32'd2);
        check("s1_ready_off", get_ready(0), 32'd0);
        set_in(1'b0, 4'b0, 32'h0, 4'b0);
        tick();
        check("s1_dv_width", get_dv(0), 32'd0);
        repeat (5208) tick();
        pulse_done(0);
        check("s1_busy_next", get_busy(0), 32'd1);
        tick();
        check("s1_busy_release", get_busy(0), 32'd1);
        tick();
        check("s1_busy_idle", get_busy(0), 32'd0);
        check("s1_gid_hold", get_gid(0), 32'd2);
        check("s1_terr", get_terr(0), 32'd0);

        // Round-robin table from a fresh rr_ptr
        reset_dut();
        for (int k = 0; k < 11; k++) begin
            set_in(1'b0, vecs[k].valid, vecs[k].data, 4'b1111);
            wait_dv(0, $sformatf("rr%0d", k), vecs[k].exp_gid, vecs[k].exp_byte, lat);
            check($sformatf("rr%0d_lat", k), 32'(lat), 32'd2);
            set_in(1'b0, 4'b0, 32'h0, 4'b0);
            tick();
            pulse_done(0);
            wait_idle(0, $sformatf("rr%0d", k));
        end

        // Packet lock: port 1 holds the grant for three bytes, rr_ptr is 1
        set_in(1'b0, 4'b0011, 32'h00001155, 4'b0000);
        wait_dv(0, "lock0", 1, 8'h11, lat);
        check("lock0_lat", 32'(lat), 32'd2);
        set_in(1'b0, 4'b0011, 32'h00002255, 4'b0000);
        pulse_done(0);
        wait_dv(0, "lock1", 1, 8'h22, lat);
        check("lock1_lat", 32'(lat), 32'd2);
        set_in(1'b0, 4'b0011, 32'h00003355, 4'b0010);
        pulse_done(0);
        wait_dv(0, "lock2", 1, 8'h33, lat);
        check("lock2_lat", 32'(lat), 32'd2);
        set_in(1'b0, 4'b0001, 32'h00000055, 4'b0001);
        pulse_done(0);
        wait_dv(0, "lock_p0", 0, 8'h55, lat);
        check("lock_p0_lat", 32'(lat), 32'd4);
        set_in(1'b0, 4'b0, 32'h0, 4'b0);
        pulse_done(0);
        wait_idle(0, "lock");

        // Watchdog: rr_ptr is 1, so port 3 wins over port 0
        set_in(1'b0, 4'b1001, 32'hA5000077, 4'b1111);
        wait_dv(0, "wd", 3, 8'hA5, lat);
        set_in(1'b0, 4'b0001, 32'h00000077, 4'b1111);
        n = 0;
        while (get_terr(0) != 32'd1 && n < 7000) begin
            tick();
            n++;
        end
        check("wd_time", 32'(n), 32'd6252);
        tick();
        check("wd_pulse_width", get_terr(0), 32'd0);
        wait_dv(0, "wd_next", 0, 8'h77, lat);
        set_in(1'b0, 4'b0, 32'h0, 4'b0);
        pulse_done(0);
        wait_idle(0, "wd");

        // Withdrawal: port 3 wins, then drops valid before the handshake
        set_in(1'b0, 4'b1001, 32'hBB000066, 4'b1111);
        tick();
        check("wdraw_gid", get_gid(0), 32'd3);
        check("wdraw_ready", get_ready(0), 32'h8);
        set_in(1'b0, 4'b0001, 32'hBB000066, 4'b1111);
        wait_dv(0, "wdraw", 0, 8'h66, lat);
        check("wdraw_lat", 32'(lat), 32'd4);
        set_in(1'b0, 4'b0, 32'h0, 4'b0);
        pulse_done(0);
        wait_idle(0, "wdraw");

        // Reset in the tx_dv cycle; rr_ptr was 1 so port 3 would win without it
        set_in(1'b0, 4'b0100, 32'h00C40000, 4'b1111);
        wait_dv(0, "rst_pre", 2, 8'hC4, lat);
        set_in(1'b0, 4'b1001, 32'h3C00000F, 4'b1111);
        #1 tx_rst_n = 1'b0;
        #1;
        check("rstmid_dv", get_dv(0), 32'd0);
        check("rstmid_busy", get_busy(0), 32'd0);
        check("rstmid_gid", get_gid(0), 32'd0);
        check("rstmid_byte", get_byte(0), 32'd0);
        @(negedge tx_clk);
        tick();
        check("rstmid_ready", get_ready(0), 32'd0);
        tx_rst_n = 1'b1;
        wait_dv(0, "rst_post", 0, 8'h0F, lat);
        check("rst_post_lat", 32'(lat), 32'd2);
        set_in(1'b0, 4'b0, 32'h0, 4'b0);
        pulse_done(0);
        wait_idle(0, "rst_post");

        // dut_b: burst cap of 2 with last never set, 3-clock gap
        set_in(1'b1, 4'b0011, 32'h00007170, 4'b0000);
        wait_dv(1, "b_burst0", 0, 8'h70, lat);
        pulse_done(1);
        wait_dv(1, "b_burst1", 0, 8'h70, lat);
        check("b_gap_lat", 32'(lat), 32'd5);
        pulse_done(1);
        wait_dv(1, "b_burst2", 1, 8'h71, lat);
        check("b_rotate_lat", 32'(lat), 32'd7);
        set_in(1'b1, 4'b0, 32'h0, 4'b0);
        pulse_done(1);
        wait_idle(1, "b_burst");

        // dut_b: tx_done on the watchdog expiry cycle counts as done
        set_in(1'b1, 4'b0100, 32'h005E0000, 4'b0100);
        wait_dv(1, "b_coin", 2, 8'h5E, lat);
        set_in(1'b1, 4'b0, 32'h0, 4'b0);
        repeat (119) tick();
        check("b_coin_pre_terr", get_terr(1), 32'd0);
        pulse_done(1);
        seen = get_terr(1)[0];
        n = 0;
        while (get_busy(1) != 32'd0 && n < 40) begin
            tick();
            n++;
            if (get_terr(1) != 32'd0) seen = 1'b1;
        end
        check("b_coin_terr", 32'(seen), 32'd0);
        check("b_coin_idle_lat", 32'(n), 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
